// File: rtl/key_sw_input_control.sv
// key_sw_input_control
//   Avalon-MM read-side peripheral for four active-low push-buttons and eight
//   slide switches. Keys are synchronised, debounced and press events latched
//   in a write-1-to-clear edge register. A level interrupt is raised while any
//   unmasked press event is pending.
//
// Ports
//   iClk, iReset_n            clock, asynchronous active-low reset
//   iChip_select_n            bus select (active-low)
//   iRead_n / iWrite_n        read / write strobes (active-low, qualified by select)
//   iAddress[1:0]             0: switches, 1: debounced keys, 2: edge (W1C), 3: mask
//   iWrite_data[7:0]          write data
//   oRead_data[7:0]           registered read data, latency 1
//   iKey[3:0]                 raw push-buttons, low when pressed
//   iSw[7:0]                  raw slide switches
//   oIrq                      |(edge & mask)
module key_sw_input_control #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic       iClk,
  input  logic       iReset_n,
  input  logic       iChip_select_n,
  input  logic       iRead_n,
  input  logic       iWrite_n,
  input  logic [1:0] iAddress,
  input  logic [7:0] iWrite_data,
  output logic [7:0] oRead_data,
  input  logic [3:0] iKey,
  input  logic [7:0] iSw,
  output logic       oIrq
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  // Synchronisers
  logic [3:0] key_s1, key_s2;
  logic [7:0] sw_s1, sw_s2;

  // Debounce state; key_db is stored as pressed = 1
  logic [3:0]      key_db_q, key_db_d;
  logic [CntW-1:0] cnt_q [4];
  logic [CntW-1:0] cnt_d [4];

  logic [3:0] edge_q, edge_d;
  logic [3:0] mask_q, mask_d;
  logic [7:0] read_data_q;
  logic [7:0] rd_val;

  logic bus_rd, bus_wr;
  logic [3:0] key_rise;
  logic [3:0] w1c;

  // Upper write-data bits have no destination
  logic unused_wdata;
  assign unused_wdata = ^iWrite_data[7:4];

  assign bus_rd = !iChip_select_n && !iRead_n;
  assign bus_wr = !iChip_select_n && !iWrite_n;

  // Debounce next state: the counter only runs while the synchronised key
  // disagrees with the stable value, so any disagreement shorter than
  // DEBOUNCE_CYCLES resets it without touching key_db.
  always_comb begin
    key_db_d = key_db_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (~key_s2[i] != key_db_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          key_db_d[i] = ~key_s2[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  assign key_rise = key_db_d & ~key_db_q;
  assign w1c      = (bus_wr && iAddress == 2'd2) ? iWrite_data[3:0] : 4'h0;

  // Set wins over a same-cycle clear
  assign edge_d = (edge_q & ~w1c) | key_rise;
  assign mask_d = (bus_wr && iAddress == 2'd3) ? iWrite_data[3:0] : mask_q;

  // Read mux sees pre-write register values, so a combined read/write
  // returns the old contents.
  always_comb begin
    rd_val = 8'h00;
    unique case (iAddress)
      2'd0: rd_val = sw_s2;
      2'd1: rd_val = {4'h0, key_db_q};
      2'd2: rd_val = {4'h0, edge_q};
      2'd3: rd_val = {4'h0, mask_q};
      default: rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      key_s1      <= 4'hF;
      key_s2      <= 4'hF;
      sw_s1       <= 8'h00;
      sw_s2       <= 8'h00;
      key_db_q    <= 4'h0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      edge_q      <= 4'h0;
      mask_q      <= 4'h0;
      read_data_q <= 8'h00;
    end else begin
      key_s1   <= iKey;
      key_s2   <= key_s1;
      sw_s1    <= iSw;
      sw_s2    <= sw_s1;
      key_db_q <= key_db_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      edge_q   <= edge_d;
      mask_q   <= mask_d;
      if (bus_rd) read_data_q <= rd_val;
    end
  end

  assign oRead_data = read_data_q;
  assign oIrq       = |(edge_q & mask_q);

endmodule

// File: tb/tb_key_sw_input_control.sv
// Self-checking bench for key_sw_input_control with DEBOUNCE_CYCLES = 4.
module tb_key_sw_input_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n = 1'b1;
  logic       rd_n = 1'b1;
  logic       wr_n = 1'b1;
  logic [1:0] addr = 2'd0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic [3:0] key = 4'hF;
  logic [7:0] sw = 8'h00;
  logic       irq;

  key_sw_input_control #(.DEBOUNCE_CYCLES(4)) dut (
    .iClk           (clk),
    .iReset_n       (rst_n),
    .iChip_select_n (cs_n),
    .iRead_n        (rd_n),
    .iWrite_n       (wr_n),
    .iAddress       (addr),
    .iWrite_data    (wdata),
    .oRead_data     (rdata),
    .iKey           (key),
    .iSw            (sw),
    .oIrq           (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  typedef struct {
    string      name;
    logic [7:0] sw;
    logic       wr;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[7];

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, got, exp);
    end
  endtask

  // Scoreboard monitor: a read strobe seen at a rising edge is answered
  // by oRead_data just after that edge.
  always @(posedge clk) begin
    if (rst_n && !cs_n && !rd_n) begin
      #1;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_read: got 0x%02h expected no read", rdata);
      end else begin
        mon_e = sb_q.pop_front();
        check8(mon_e.name, rdata, mon_e.exp);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [7:0] exp, input string name);
    addr = a;
    cs_n = 1'b0;
    rd_n = 1'b0;
    sb_q.push_back('{name: name, exp: exp});
    tick();
    cs_n = 1'b1;
    rd_n = 1'b1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    addr  = a;
    wdata = d;
    cs_n  = 1'b0;
    wr_n  = 1'b0;
    tick();
    cs_n = 1'b1;
    wr_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{name: "sw_a5",              sw: 8'hA5, wr: 1'b0, addr: 2'd0, wdata: 8'h00, exp: 8'hA5};
    vecs[1] = '{name: "sw_3c",              sw: 8'h3C, wr: 1'b0, addr: 2'd0, wdata: 8'h00, exp: 8'h3C};
    vecs[2] = '{name: "sw_write_ignored",   sw: 8'h3C, wr: 1'b1, addr: 2'd0, wdata: 8'h55, exp: 8'h3C};
    vecs[3] = '{name: "keydb_wr_ignored",   sw: 8'h3C, wr: 1'b1, addr: 2'd1, wdata: 8'hFF, exp: 8'h00};
    vecs[4] = '{name: "edge_w1c_empty",     sw: 8'h3C, wr: 1'b1, addr: 2'd2, wdata: 8'hFF, exp: 8'h00};
    vecs[5] = '{name: "mask_upper_ignored", sw: 8'h3C, wr: 1'b1, addr: 2'd3, wdata: 8'hFF, exp: 8'h0F};
    vecs[6] = '{name: "mask_clear",         sw: 8'h3C, wr: 1'b1, addr: 2'd3, wdata: 8'hF0, exp: 8'h00};

    // Reset state
    tick(2);
    check8("reset_rdata", rdata, 8'h00);
    check8("reset_irq", {7'h0, irq}, 8'h00);
    rst_n = 1'b1;
    tick(2);

    // Register map vectors
    foreach (vecs[i]) begin
      sw = vecs[i].sw;
      tick(3);
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
      bus_read(vecs[i].addr, vecs[i].exp, vecs[i].name);
    end

    // Read and write together: read returns the pre-write value
    addr  = 2'd3;
    wdata = 8'h09;
    cs_n  = 1'b0;
    rd_n  = 1'b0;
    wr_n  = 1'b0;
    sb_q.push_back('{name: "rw_same_cycle_old", exp: 8'h00});
    tick();
    cs_n = 1'b1;
    rd_n = 1'b1;
    wr_n = 1'b1;
    bus_read(2'd3, 8'h09, "rw_same_cycle_new");
    bus_write(2'd3, 8'h00);

    // Glitch shorter than the debounce window
    key = 4'hE;
    tick(3);
    key = 4'hF;
    tick(8);
    bus_read(2'd1, 8'h00, "glitch_keydb");
    bus_read(2'd2, 8'h00, "glitch_edge");

    // Key 0 held: key_db changes at edge 6 after the input change
    key = 4'hE;
    tick(5);
    bus_read(2'd1, 8'h00, "press_at_edge6_old");
    bus_read(2'd1, 8'h01, "press_after_edge6");
    bus_read(2'd2, 8'h01, "press_edge");

    // IRQ path
    check8("irq_masked_off", {7'h0, irq}, 8'h00);
    bus_write(2'd3, 8'h01);
    check8("irq_on", {7'h0, irq}, 8'h01);
    bus_write(2'd2, 8'h01);
    check8("irq_after_w1c", {7'h0, irq}, 8'h00);
    bus_read(2'd2, 8'h00, "edge_after_w1c");

    key = 4'hC;
    tick(8);
    bus_read(2'd2, 8'h02, "key1_edge");
    check8("key1_irq_masked", {7'h0, irq}, 8'h00);

    // Set/clear collision on bit 2; bit 1 cleared in the same write
    bus_write(2'd3, 8'h04);
    key = 4'h8;
    tick(5);
    bus_write(2'd2, 8'h06);
    check8("collision_irq", {7'h0, irq}, 8'h01);
    bus_read(2'd2, 8'h04, "collision_edge");

    // Release of key 0
    key = 4'h9;
    tick(5);
    bus_read(2'd1, 8'h07, "release_at_edge6_old");
    bus_read(2'd1, 8'h06, "release_after_edge6");
    bus_read(2'd2, 8'h04, "release_edge_unchanged");

    // Mid-run reset
    check8("irq_before_reset", {7'h0, irq}, 8'h01);
    key   = 4'hF;
    rst_n = 1'b0;
    #2;
    check8("midreset_rdata", rdata, 8'h00);
    check8("midreset_irq", {7'h0, irq}, 8'h00);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    bus_read(2'd1, 8'h00, "post_reset_keydb");
    bus_read(2'd2, 8'h00, "post_reset_edge");
    bus_read(2'd3, 8'h00, "post_reset_mask");

    tick(2);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
